hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the EX-stage operand-forwarding mux and decides everything forwarding cannot resolve: it stalls IF/ID on load-use hazards, flushes on taken branches and jumps, and schedules the multi-cycle multiply/divide unit, holding back HI/LO consumers until the result is ready. It drives the PC-enable, IF/ID-enable, IF/ID-flush and ID/EX-bubble controls.

## Interface
Parameters:
- MULT_LAT, default 4: cycles from `md_start_EX` to the HI/LO result being valid for a multiply.
- DIV_LAT, default 32: the same latency for a divide.
- CNT_W, default 6: width of the busy down-counter. Must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rs_ID`  in  5  rs field of the instruction in ID.
- `rt_ID`  in  5  rt field of the instruction in ID.
- `use_rt_ID`  in  1  ID instruction reads rt as a source (not only as a destination).
- `Rw_EX`  in  5  destination register of the instruction in EX.
- `MemRead_EX`  in  1  EX instruction is a load.
- `md_use_ID`  in  1  ID instruction is mfhi, mflo, mthi, mtlo, mult or div.
- `md_start_EX`  in  1  EX instruction is mult/div and is valid (not a bubble).
- `md_is_div_EX`  in  1  when 1, selects DIV_LAT; when 0, selects MULT_LAT.
- `BranchTaken_EX`  in  1  branch in EX resolved taken.
- `Jump_ID`  in  1  ID instruction is j, jal or jr.
- `PCWrite`  out  1  PC enable.
- `IFIDWrite`  out  1  IF/ID register enable.
- `IFIDFlush`  out  1  zero the IF/ID register.
- `IDEXBubble`  out  1  load a nop into ID/EX.
- `md_busy`  out  1  registered; the mult/div unit is occupied.
- `md_done`  out  1  registered; one-cycle pulse when the result becomes valid.
- `stall_cnt`  out  32  stall-cycle counter (only with the macro described under Configuration).
- `flush_cnt`  out  32  flush-event counter (only with the macro described under Configuration).

## Operation
- `load_use` = `MemRead_EX` && `Rw_EX` != 0 && (`Rw_EX` == `rs_ID` || (`use_rt_ID` && `Rw_EX` == `rt_ID`)).
- `md_hazard` = `md_use_ID` && (state == BUSY || `md_start_EX`). A back-to-back mult/div consumer stalls even in the start cycle.
- `stall` = (`load_use` || `md_hazard`) && !`BranchTaken_EX`.
- Stall outputs: `PCWrite` = `IFIDWrite` = !`stall`; `IDEXBubble` = `stall` || `BranchTaken_EX`.
- Flush: `IFIDFlush` = `BranchTaken_EX` || (`Jump_ID` && !`stall`).
- Priority: a taken branch beats every stall, because the ID instruction is discarded anyway. A stalled jump does not flush until its stall clears.
- FSM with two states, IDLE and BUSY:
  - IDLE → BUSY on `md_start_EX`. The counter loads DIV_LAT−1 or MULT_LAT−1.
  - BUSY: the counter decrements each cycle. When counter == 0: `md_done` = 1 for the next cycle, `md_busy` drops, and the state returns to IDLE.
  - `md_start_EX` while BUSY is illegal, because the stall prevents it; the block ignores it (no reload).
- `md_busy` = (state == BUSY).

## Timing
- Reset (`rst_n` = 0 at a clock edge): state IDLE, counter 0, `md_busy` = 0, `md_done` = 0, both perf counters 0.
- All stall and flush outputs are combinational from the inputs and the state. With reset asserted and all inputs 0, they are `PCWrite` = 1, `IFIDWrite` = 1, `IFIDFlush` = 0, `IDEXBubble` = 0.
- Load-use stall: exactly 1 cycle per hazard. The load moves to MEM and the forwarding mux supplies the data.
- Mult/div latency: `md_start_EX` at edge N gives `md_busy` high from N+1 to N+LAT, and `md_done` high in cycle N+LAT+1. HI/LO consumers in ID stall through cycle N+LAT and proceed at N+LAT+1.
- Reset mid-operation: BUSY is abandoned immediately and no `md_done` is issued.
- A taken branch in the same cycle as `md_start_EX` still starts the unit, because the mult/div is older than the branch.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments in every cycle with `stall` = 1.
  - `flush_cnt` increments in every cycle with `IFIDFlush` = 1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: no counter flops exist, and both outputs are tied to 0.

## Test plan
- Load-use: lw $3 in EX (`MemRead_EX` = 1, `Rw_EX` = 3) with `rs_ID` = 3 → exactly one cycle of `PCWrite` = 0, `IFIDWrite` = 0, `IDEXBubble` = 1, then normal flow.
- $0 and unused rt: `Rw_EX` = 0 with `rs_ID` = 0 → no stall. `Rw_EX` = 5, `rt_ID` = 5, `use_rt_ID` = 0 → no stall.
- Divide: `md_start_EX` = 1 with `md_is_div_EX` = 1, then mflo held in ID → `md_busy` high for 32 cycles, ID stalled for 32 cycles, `md_done` pulses in cycle 33, and mflo proceeds that same cycle.
- Branch vs. stall: `load_use` and `BranchTaken_EX` both high → `IFIDFlush` = 1, `IDEXBubble` = 1, `PCWrite` = 1. With the macro defined, `flush_cnt` +1 and `stall_cnt` unchanged.
- Reset mid-multiply: `rst_n` = 0 on the 2nd BUSY cycle → next cycle `md_busy` = 0, `md_done` never asserts, and both counters read 0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - load-use/branch/jump hazard control and mult/div busy sequencing
//
// Ports:
//   clk, rst_n          : rising-edge clock, synchronous active-low reset
//   rs_ID, rt_ID        : source fields of the instruction in ID
//   use_rt_ID           : ID instruction reads rt as a source
//   Rw_EX, MemRead_EX   : destination and load flag of the instruction in EX
//   md_use_ID           : ID instruction touches HI/LO or the mult/div unit
//   md_start_EX         : valid mult/div in EX, launches the unit
//   md_is_div_EX        : selects DIV_LAT (1) or MULT_LAT (0)
//   BranchTaken_EX      : branch in EX resolved taken
//   Jump_ID             : ID instruction is j/jal/jr
//   PCWrite, IFIDWrite  : pipeline front-end enables (low while stalling)
//   IFIDFlush           : zero the IF/ID register
//   IDEXBubble          : load a nop into ID/EX
//   md_busy, md_done    : registered unit-occupied flag and one-cycle result-ready pulse
//   stall_cnt, flush_cnt: performance counters, present only when HAZARD_PERF_CNT_EN is defined
module hazard_sequencer #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNT_W    = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        use_rt_ID,
  input  logic [4:0]  Rw_EX,
  input  logic        MemRead_EX,
  input  logic        md_use_ID,
  input  logic        md_start_EX,
  input  logic        md_is_div_EX,
  input  logic        BranchTaken_EX,
  input  logic        Jump_ID,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXBubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter is loaded with LAT-1 so that BUSY lasts exactly LAT cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             done_nx;

  logic load_use;
  logic md_hazard;
  logic stall;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      md_done <= done_nx;
    end
  end

  // Next-state logic. A start request while BUSY cannot legally occur (the
  // consumer stall holds it in ID), so it is simply not looked at there.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (md_start_EX) begin
          state_nx = BUSY;
          cnt_nx   = md_is_div_EX ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output logic. The start cycle itself already blocks a HI/LO consumer,
  // since the unit has not yet registered BUSY. A taken branch discards the
  // ID instruction, so it overrides any stall.
  always_comb begin
    load_use   = MemRead_EX && (Rw_EX != 5'd0) &&
                 ((Rw_EX == rs_ID) || (use_rt_ID && (Rw_EX == rt_ID)));
    md_hazard  = md_use_ID && ((state == BUSY) || md_start_EX);
    stall      = (load_use || md_hazard) && !BranchTaken_EX;
    PCWrite    = !stall;
    IFIDWrite  = !stall;
    IDEXBubble = stall || BranchTaken_EX;
    IFIDFlush  = BranchTaken_EX || (Jump_ID && !stall);
  end

  assign md_busy = (state == BUSY);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall)     stall_q <= stall_q + 32'd1;
      if (IFIDFlush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_ID;
  logic [4:0]  rt_ID;
  logic        use_rt_ID;
  logic [4:0]  Rw_EX;
  logic        MemRead_EX;
  logic        md_use_ID;
  logic        md_start_EX;
  logic        md_is_div_EX;
  logic        BranchTaken_EX;
  logic        Jump_ID;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_ID          (rs_ID),
    .rt_ID          (rt_ID),
    .use_rt_ID      (use_rt_ID),
    .Rw_EX          (Rw_EX),
    .MemRead_EX     (MemRead_EX),
    .md_use_ID      (md_use_ID),
    .md_start_EX    (md_start_EX),
    .md_is_div_EX   (md_is_div_EX),
    .BranchTaken_EX (BranchTaken_EX),
    .Jump_ID        (Jump_ID),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IFIDFlush      (IFIDFlush),
    .IDEXBubble     (IDEXBubble),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic [4:0] rw;
    logic       memread;
    logic       md_use;
    logic       md_start;
    logic       md_div;
    logic       br;
    logic       jump;
  } in_t;

  // expected outputs: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, md_busy, md_done}
  typedef struct {
    string      name;
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [5:0]  sbq[$];
  string       nameq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;

  function automatic in_t mk(logic [4:0] rs, logic [4:0] rt, logic use_rt, logic [4:0] rw,
                             logic memread, logic md_use, logic md_start, logic md_div,
                             logic br, logic jump);
    in_t i;
    i.rst_n = 1'b1; i.rs = rs; i.rt = rt; i.use_rt = use_rt; i.rw = rw;
    i.memread = memread; i.md_use = md_use; i.md_start = md_start; i.md_div = md_div;
    i.br = br; i.jump = jump;
    return i;
  endfunction

  function automatic in_t mk_rst();
    in_t i;
    i = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i.rst_n = 1'b0;
    return i;
  endfunction

  function automatic in_t mk_md(logic md_use, logic md_start, logic md_div, logic br);
    return mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, md_use, md_start, md_div, br, 1'b0);
  endfunction

  task automatic add_vec(string n, in_t i, logic [3:0] e);
    vec_t v;
    v.name = n; v.in = i; v.exp = {e, 2'b00};
    tbl.push_back(v);
  endtask

  task automatic check_out();
    logic [5:0] e;
    logic [5:0] act;
    string      n;
    e   = sbq.pop_front();
    n   = nameq.pop_front();
    act = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, md_busy, md_done};
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: outputs {pcw,ifw,flush,bub,busy,done} got %b want %b", n, act, e);
    end
    n_vec++;
    if (stall_cnt !== exp_stall) begin
      n_err++;
      $display("FAIL %s stall_cnt: got %0d want %0d", n, stall_cnt, exp_stall);
    end
    n_vec++;
    if (flush_cnt !== exp_flush) begin
      n_err++;
      $display("FAIL %s flush_cnt: got %0d want %0d", n, flush_cnt, exp_flush);
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge, then
  // advance the counter model to what the next rising edge will register.
  task automatic step(string name, in_t i, logic [5:0] e);
    @(posedge clk);
    #1;
    rst_n = i.rst_n; rs_ID = i.rs; rt_ID = i.rt; use_rt_ID = i.use_rt;
    Rw_EX = i.rw; MemRead_EX = i.memread; md_use_ID = i.md_use;
    md_start_EX = i.md_start; md_is_div_EX = i.md_div;
    BranchTaken_EX = i.br; Jump_ID = i.jump;
    sbq.push_back(e);
    nameq.push_back(name);
    @(negedge clk);
    check_out();
    if (!i.rst_n) begin
      exp_stall = 32'd0;
      exp_flush = 32'd0;
    end else if (PERF) begin
      exp_stall = exp_stall + 32'(!e[5]);
      exp_flush = exp_flush + 32'(e[3]);
    end
  endtask

  initial begin
    rst_n = 1'b0; rs_ID = '0; rt_ID = '0; use_rt_ID = 1'b0; Rw_EX = '0;
    MemRead_EX = 1'b0; md_use_ID = 1'b0; md_start_EX = 1'b0; md_is_div_EX = 1'b0;
    BranchTaken_EX = 1'b0; Jump_ID = 1'b0;

    //              rs     rt    use_rt rw   mem   md_use start div   br    jump     {pcw,ifw,fl,bub}
    add_vec("idle",        mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b1100);
    add_vec("lu_rs",       mk(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b0001);
    add_vec("lu_r0",       mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b1100);
    add_vec("rt_unused",   mk(5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b1100);
    add_vec("lu_rt",       mk(5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b0001);
    add_vec("no_load",     mk(5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b1100);
    add_vec("lu_mismatch", mk(5'd4, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 4'b1100);
    add_vec("br_vs_lu",    mk(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 4'b1111);
    add_vec("jump",        mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 4'b1110);
    add_vec("jump_stall",  mk(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 4'b0001);
    add_vec("branch",      mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 4'b1111);
    add_vec("md_use_idle", mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 4'b1100);

    step("reset0", mk_rst(), 6'b110000);
    step("reset1", mk_rst(), 6'b110000);

    foreach (tbl[k]) step(tbl[k].name, tbl[k].in, tbl[k].exp);

    // load-use lasts exactly one cycle: the load then leaves EX
    step("lu_stall", mk(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'b000100);
    step("lu_after", mk(5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 6'b110000);

    // multiply with a HI/LO consumer already in ID during the start cycle
    step("mul_start", mk_md(1'b1, 1'b1, 1'b0, 1'b0), 6'b000100);
    for (int k = 1; k <= 4; k++) step($sformatf("mul_busy%0d", k), mk_md(1'b1, 1'b0, 1'b0, 1'b0), 6'b000110);
    step("mul_done", mk_md(1'b1, 1'b0, 1'b0, 1'b0), 6'b110001);
    step("mul_post", mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110000);

    // divide, mflo arrives after start; a stray start mid-BUSY must not reload
    step("div_start", mk_md(1'b0, 1'b1, 1'b1, 1'b0), 6'b110000);
    for (int k = 1; k <= 32; k++)
      step($sformatf("div_busy%0d", k), mk_md(1'b1, (k == 10), 1'b0, 1'b0), 6'b000110);
    step("div_done", mk_md(1'b1, 1'b0, 1'b0, 1'b0), 6'b110001);
    step("div_post", mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110000);

    // taken branch in the start cycle: no stall, but the unit still starts
    step("br_start", mk_md(1'b1, 1'b1, 1'b0, 1'b1), 6'b111100);
    for (int k = 1; k <= 4; k++) step($sformatf("br_busy%0d", k), mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110010);
    step("br_done", mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110001);
    step("br_post", mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110000);

    // reset on the 2nd BUSY cycle of a multiply abandons it without md_done
    step("rst_start", mk_md(1'b0, 1'b1, 1'b0, 1'b0), 6'b110000);
    step("rst_busy1", mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110010);
    step("rst_busy2", mk_rst(), 6'b110010);
    for (int k = 1; k <= 5; k++) step($sformatf("rst_after%0d", k), mk_md(1'b0, 1'b0, 1'b0, 1'b0), 6'b110000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
